// File: rtl/acc_pkg.sv
// Shared accelerator datapath definitions: default element geometry, pooling FSM states
// and the element-wise max helper used by the pooling units.
package acc_pkg;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_LANES = 24;
  localparam int unsigned OUT_LANES = DEF_LANES / 2;

  typedef enum logic [0:0] {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // Ties keep operand a, so callers pass the lower-index or buffered element first.
  function automatic logic [DEF_DW-1:0] max2(input logic [DEF_DW-1:0] a,
                                             input logic [DEF_DW-1:0] b,
                                             input logic              signed_mode);
    logic b_gt;
    b_gt = signed_mode ? ($signed(b) > $signed(a)) : (b > a);
    return b_gt ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_lane_reduce.sv
// Combinational lane reduction for 2x2 max pooling: pairwise horizontal max of one beat,
// then vertical max against a buffered even-row entry. MAXPOOL_STREAM_RELU_EN fuses a ReLU.
module maxpool_lane_reduce
  import acc_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LANES = DEF_LANES
) (
  input  logic                      signed_mode,
  input  logic [LANES*DW-1:0]       in_data,
  input  logic [(LANES/2)*DW-1:0]   lb_data,
  output logic [(LANES/2)*DW-1:0]   h_c,
  output logic [(LANES/2)*DW-1:0]   pool_c
);

  localparam int unsigned OL = LANES / 2;

  always_comb begin
    h_c    = '0;
    pool_c = '0;
    for (int unsigned j = 0; j < OL; j++) begin
      h_c[j*DW +: DW]    = max2(in_data[(2*j)*DW +: DW], in_data[(2*j+1)*DW +: DW], signed_mode);
      pool_c[j*DW +: DW] = max2(lb_data[j*DW +: DW], h_c[j*DW +: DW], signed_mode);
`ifdef MAXPOOL_STREAM_RELU_EN
      if (signed_mode && pool_c[j*DW + DW - 1]) begin
        pool_c[j*DW +: DW] = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/maxpool_stream_2x2.sv
// Streaming 2x2 / stride-2 max pooling: even row is pair-reduced into a line buffer, odd row
// is combined with it and emitted through a single output register. Optional MAXPOOL_STREAM_RELU_EN.
module maxpool_stream_2x2
  import acc_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned BW        = $clog2(MAX_BEATS) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BW-1:0]           cfg_beats,
  input  logic                    cfg_signed,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(LANES/2)*DW-1:0] out_data,
  output logic                    busy,
  output logic [31:0]             pool_cnt
);

  localparam int unsigned OW = (LANES / 2) * DW;
  localparam int unsigned IW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt, cnt_nxt;
  logic [BW-1:0]   cfg_beats_q;
  logic            cfg_signed_q;
  logic            cfg_sample_c;
  logic [BW-1:0]   beats_raw_c, beats_eff_c;
  logic            signed_eff_c;
  logic            accept_c, load_c, out_valid_nxt;
  logic [OW-1:0]   h_c, pool_c, lb_rd_c;
  logic [OW-1:0]   linebuf [MAX_BEATS];

  // Config is live while idle at the start of an even row, latched otherwise.
  always_comb begin
    cfg_sample_c = (state == EVEN) && (beat_cnt == '0);
    beats_raw_c  = cfg_sample_c ? cfg_beats : cfg_beats_q;
    signed_eff_c = cfg_sample_c ? cfg_signed : cfg_signed_q;
    beats_eff_c  = beats_raw_c;
    if (beats_raw_c == '0) begin
      beats_eff_c = BW'(1);
    end else if (beats_raw_c > BW'(MAX_BEATS)) begin
      beats_eff_c = BW'(MAX_BEATS);
    end
  end

  assign lb_rd_c = linebuf[beat_cnt[IW-1:0]];

  maxpool_lane_reduce #(
    .DW    (DW),
    .LANES (LANES)
  ) u_reduce (
    .signed_mode (signed_eff_c),
    .in_data     (in_data),
    .lb_data     (lb_rd_c),
    .h_c         (h_c),
    .pool_c      (pool_c)
  );

  // Next-state, handshake and output-valid logic; odd-row ready passes through the output slot.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = beat_cnt;
    in_ready      = 1'b1;
    out_valid_nxt = out_valid;
    if (state == ODD) begin
      in_ready = !out_valid || out_ready;
    end
    accept_c = in_valid && in_ready;
    load_c   = accept_c && (state == ODD);
    if (accept_c) begin
      if (beat_cnt == beats_eff_c - BW'(1)) begin
        cnt_nxt   = '0;
        state_nxt = (state == EVEN) ? ODD : EVEN;
      end else begin
        cnt_nxt = beat_cnt + BW'(1);
      end
    end
    if (load_c) begin
      out_valid_nxt = 1'b1;
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= EVEN;
      beat_cnt     <= '0;
      cfg_beats_q  <= BW'(MAX_BEATS);
      cfg_signed_q <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      pool_cnt     <= '0;
      busy         <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= cnt_nxt;
      out_valid <= out_valid_nxt;
      busy      <= (state_nxt != EVEN) || (cnt_nxt != '0) || out_valid_nxt;
      if (cfg_sample_c) begin
        cfg_beats_q  <= cfg_beats;
        cfg_signed_q <= cfg_signed;
      end
      if (load_c) begin
        out_data <= pool_c;
        pool_cnt <= pool_cnt + 32'd1;
      end
    end
  end

  // Line buffer holds data only; it is never read before being written in the same window.
  always_ff @(posedge clock) begin
    if (accept_c && (state == EVEN)) begin
      linebuf[beat_cnt[IW-1:0]] <= h_c;
    end
  end

endmodule

// File: tb/tb_maxpool_stream_2x2.sv
// Directed bench for maxpool_stream_2x2: hand-computed vectors plus a 2x2 window model.
module tb_maxpool_stream_2x2;

  localparam int unsigned DW        = 16;
  localparam int unsigned LANES     = 24;
  localparam int unsigned OL        = LANES / 2;
  localparam int unsigned MAX_BEATS = 8;
  localparam int unsigned BW        = 4;
  localparam int unsigned IN_W      = LANES * DW;
  localparam int unsigned OUT_W     = OL * DW;

  logic             clock;
  logic             reset;
  logic [BW-1:0]    cfg_beats;
  logic             cfg_signed;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;
  logic [31:0]      pool_cnt;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int exp_pool = 0;
  logic [OUT_W-1:0] got_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int               stamp_q[$];

  maxpool_stream_2x2 #(
    .DW(DW), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .BW(BW)
  ) dut (
    .clock(clock), .reset(reset), .cfg_beats(cfg_beats), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .pool_cnt(pool_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Captures every output handshake that completes at the following rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got_q.push_back(out_data);
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] fill_in(input logic [DW-1:0] v);
    logic [IN_W-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [OUT_W-1:0] fill_out(input logic [DW-1:0] v);
    logic [OUT_W-1:0] d;
    for (int j = 0; j < OL; j++) d[j*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [IN_W-1:0] gen_beat(input int seed, input int b);
    logic [IN_W-1:0] d;
    for (int k = 0; k < LANES; k++)
      d[k*DW +: DW] = DW'(seed*131 + b*977 + k*53 - 700 + (k % 3)*4096);
    return d;
  endfunction

  // Reference: max of the four window elements, then optional ReLU.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] e, input logic [IN_W-1:0] o,
                                             input logic sgn);
    logic [OUT_W-1:0] r;
    logic [DW-1:0]    v[4];
    logic [DW-1:0]    best;
    for (int j = 0; j < OL; j++) begin
      v[0] = e[(2*j)*DW +: DW];
      v[1] = e[(2*j+1)*DW +: DW];
      v[2] = o[(2*j)*DW +: DW];
      v[3] = o[(2*j+1)*DW +: DW];
      best = v[0];
      for (int i = 1; i < 4; i++)
        if (sgn ? ($signed(v[i]) > $signed(best)) : (v[i] > best)) best = v[i];
`ifdef MAXPOOL_STREAM_RELU_EN
      if (sgn && best[DW-1]) best = '0;
`endif
      r[j*DW +: DW] = best;
    end
    return r;
  endfunction

  // Called and returns at posedge+1; leaves the beat accepted at the last edge.
  task automatic send_beat(input logic [IN_W-1:0] d);
    int   n;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      #3;
      ok = in_ready;
      @(posedge clock);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", OUT_W'(in_ready), OUT_W'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_window(input int nb, input int seed, input logic sgn);
    logic [IN_W-1:0] ev[MAX_BEATS];
    logic [IN_W-1:0] od;
    for (int b = 0; b < nb; b++) begin
      ev[b] = gen_beat(seed, b);
      send_beat(ev[b]);
    end
    for (int b = 0; b < nb; b++) begin
      od = gen_beat(seed + 7, nb - 1 - b);
      exp_q.push_back(model(ev[b], od, sgn));
      exp_pool++;
      send_beat(od);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input bit consec);
    int n;
    check($sformatf("%s_count", tag), OUT_W'(got_q.size()), OUT_W'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
      if (consec && i > 0)
        check($sformatf("%s_gap%0d", tag, i), OUT_W'(stamp_q[i] - stamp_q[i-1]), OUT_W'(1));
    end
    got_q.delete();
    exp_q.delete();
    stamp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]  d_ev, d_od;
    logic [OUT_W-1:0] e1, snap;
    int               n;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_beats = BW'(1); cfg_signed = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_pool_cnt", OUT_W'(pool_cnt), OUT_W'(0));
    check("rst_busy", OUT_W'(busy), OUT_W'(0));
    check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    reset = 1'b0;
    drain(1);

    // Ramp: even lane k = k, odd lane k = -k -> pooled j = 2j+1
    for (int k = 0; k < LANES; k++) begin
      d_ev[k*DW +: DW] = DW'(k);
      d_od[k*DW +: DW] = DW'(-k);
    end
    for (int j = 0; j < OL; j++) e1[j*DW +: DW] = DW'(2*j + 1);
    send_beat(d_ev);
    send_beat(d_od);
    check("t1_latency_valid", OUT_W'(out_valid), OUT_W'(1));
    check("t1_data", out_data, e1);
    exp_q.push_back(e1);
    exp_pool++;
    drain(1);
    check("t1_pool_cnt", OUT_W'(pool_cnt), OUT_W'(1));
    check("t1_valid_clear", OUT_W'(out_valid), OUT_W'(0));
    check_outputs("t1", 1'b0);

    // Signed vs unsigned compare on 0x8000 / 0x0001
    for (int s = 1; s >= 0; s--) begin
      cfg_signed = 1'(s);
      send_beat(fill_in(16'h8000));
      send_beat(fill_in(16'h0001));
      e1 = (s == 1) ? fill_out(16'h0001) : fill_out(16'h8000);
      check($sformatf("t2_sgn%0d", s), out_data, e1);
      exp_q.push_back(e1);
      exp_pool++;
    end
    cfg_signed = 1'b1;
    send_beat(fill_in(16'h8000));
    send_beat(fill_in(16'h8000));
`ifdef MAXPOOL_STREAM_RELU_EN
    e1 = fill_out(16'h0000);
`else
    e1 = fill_out(16'h8000);
`endif
    check("t2_neg", out_data, e1);
    exp_q.push_back(e1);
    exp_pool++;
    drain(2);
    check_outputs("t2", 1'b0);

    // Four-beat rows, back-to-back, no backpressure
    cfg_beats = BW'(4);
    send_window(4, 3, 1'b1);
    drain(4);
    check_outputs("t3s", 1'b1);
    cfg_signed = 1'b0;
    send_window(4, 11, 1'b0);
    drain(4);
    check_outputs("t3u", 1'b1);
    check("t3_pool_cnt", OUT_W'(pool_cnt), OUT_W'(exp_pool));

    // Backpressure during the odd row
    cfg_signed = 1'b1;
    out_ready  = 1'b0;
    fork
      send_window(4, 5, 1'b1);
      begin
        n = 0;
        while (!out_valid && n < 200) begin
          @(posedge clock);
          #1;
          n++;
        end
        check("t4_valid", OUT_W'(out_valid), OUT_W'(1));
        snap = out_data;
        repeat (10) begin
          @(posedge clock);
          #1;
          check("t4_hold", out_data, snap);
          check("t4_in_ready", OUT_W'(in_ready), OUT_W'(0));
        end
        out_ready = 1'b1;
      end
    join
    drain(4);
    check_outputs("t4", 1'b0);
    check("t4_busy", OUT_W'(busy), OUT_W'(0));

    // Reset mid even row abandons the window
    send_beat(gen_beat(9, 0));
    send_beat(gen_beat(9, 1));
    check("t5_busy_mid", OUT_W'(busy), OUT_W'(1));
    reset = 1'b1;
    #1;
    check("t5_rst_valid", OUT_W'(out_valid), OUT_W'(0));
    check("t5_rst_pool", OUT_W'(pool_cnt), OUT_W'(0));
    check("t5_rst_busy", OUT_W'(busy), OUT_W'(0));
    exp_pool = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cfg_beats = BW'(2);
    send_window(2, 13, 1'b1);
    drain(4);
    check_outputs("t5", 1'b0);
    check("t5_pool_cnt", OUT_W'(pool_cnt), OUT_W'(2));

    // Row-length clamping: 0 -> 1, 15 -> MAX_BEATS
    cfg_beats = BW'(0);
    send_window(1, 17, 1'b1);
    drain(4);
    check_outputs("t6_zero", 1'b0);
    check("t6_zero_busy", OUT_W'(busy), OUT_W'(0));
    cfg_beats  = BW'(15);
    cfg_signed = 1'b0;
    send_window(8, 19, 1'b0);
    drain(4);
    check_outputs("t6_sat", 1'b0);
    check("t6_sat_busy", OUT_W'(busy), OUT_W'(0));
    check("t6_pool_cnt", OUT_W'(pool_cnt), OUT_W'(exp_pool));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/maxpool_stream_2x2.md
Name: maxpool_stream_2x2

Overview:
- Streaming 2x2 / stride-2 max-pooling unit for the accelerator datapath.
- Consumes one image row per BEATS beats. Each beat carries LANES signed or unsigned elements.
- Buffers the pair-reduced even row in an internal line buffer, then combines it with the odd row.
- Emits one LANES/2-element pooled beat per odd-row beat over a valid/ready handshake; sits between the conv output stream and the writeback stage.

Parameters:
- DW, 16, element width in bits.
- LANES, 24, elements per input beat; must be even.
- MAX_BEATS, 8, line-buffer depth = maximum beats per image row.
- BW, $clog2(MAX_BEATS)+1, width of cfg_beats and counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_beats  in  BW  beats per row, 1..MAX_BEATS; sampled only when the FSM is in EVEN with beat_cnt==0.
- cfg_signed  in  1  1 = signed compare, 0 = unsigned; sampled with cfg_beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DW  element k at bits [DW*(k+1)-1 : DW*k].
- out_valid  out  1  pooled beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES/2*DW  pooled element j at bits [DW*(j+1)-1 : DW*j].
- busy  out  1  high when the FSM is not in EVEN with beat_cnt==0, or when out_valid is high.
- pool_cnt  out  32  pooled beats emitted since reset; wraps.

Behaviour:
- Reset (asynchronous): state=EVEN, beat_cnt=0, out_valid=0, out_data=0, pool_cnt=0, busy=0, latched cfg = {MAX_BEATS, signed}. Line-buffer contents are not reset.
- Horizontal reduce: h[j] = max(in[2j], in[2j+1]) for j in 0..LANES/2-1.
- Compare uses the latched cfg_signed. Ties select the lower-index / buffered operand; results are bit-identical either way.
- Latched cfg_beats == 0 is treated as 1. Values above MAX_BEATS saturate to MAX_BEATS.
- State EVEN:
  - in_ready=1.
  - Accepted beat: linebuf[beat_cnt] <= h, beat_cnt++.
  - When beat_cnt == cfg_beats-1 on accept: beat_cnt <= 0, go to ODD.
- State ODD:
  - in_ready = !out_valid || out_ready (single-register output with pass-through ready).
  - Accepted beat: out_data[j] <= max(linebuf[beat_cnt][j], h[j]), out_valid <= 1, beat_cnt++, pool_cnt++.
  - Last beat: beat_cnt <= 0, go to EVEN; cfg is re-sampled there.
- Latency: one cycle from an accepted odd-row beat to out_valid.
- out_valid and out_data hold stable until out_ready.
- Simultaneous out_ready and a new odd accept: the register reloads and out_valid stays 1. Throughput is 1 beat/cycle under no backpressure.
- out_valid clears on out_ready with no new load.
- EVEN-row input is never blocked by a pending output; output may still be draining during the next EVEN row.
- Backpressure on out_ready stalls only ODD-row input. No beat is dropped or duplicated.
- A reset asserted mid-row abandons the partial window. The first beat after reset is treated as an even-row beat 0.

Optional Feature:
- Macro MAXPOOL_STREAM_RELU_EN.
- Defined: each pooled element is clamped to 0 when cfg_signed=1 and its MSB=1, i.e. ReLU is fused after pooling. No added latency.
- Undefined: raw max is output; negative results pass through unchanged.

Decomposition:
- Shared package acc_pkg holds:
  - DW/LANES defaults;
  - localparam OUT_LANES = LANES/2;
  - state typedef enum {EVEN, ODD};
  - a function max2(a, b, signed_mode).
- One sub-module is natural: maxpool_lane_reduce (purely combinational). Inputs are one input beat plus one line-buffer entry; outputs are the h vector and the final max vector. It is instantiated once.
- FSM, counters, line buffer and output register live in the top.

Test Plan:
- Reset, cfg_beats=1, signed. Even beat with elements 0..23 = k, odd beat with elements 0..23 = -k -> one output, out_data[j] = 2j+1 for j=0..11; pool_cnt=1; latency 1 cycle.
- Signed vs unsigned: all even elements 0x8000, all odd elements 0x0001, cfg_beats=1.
  - cfg_signed=1 -> every output 0x0001.
  - cfg_signed=0 -> every output 0x8000.
  - With RELU_EN and signed, all-0x8000 inputs -> outputs 0x0000.
- cfg_beats=4 with continuous valid and out_ready=1 -> 4 outputs on consecutive cycles after odd beats 0..3. Each output matches the max against its own buffered even beat (line-buffer index alignment). pool_cnt=4.
- Backpressure: hold out_ready=0 during the odd row -> in_ready drops after the first output. out_data stays stable for 10 cycles. Releasing out_ready produces all 4 outputs in order, with none lost or duplicated.
- Assert reset after 2 of 4 even beats -> out_valid=0, pool_cnt=0, busy=0. A fresh cfg_beats=2 window then produces exactly 2 outputs.
- cfg_beats=0 -> behaves as 1. cfg_beats=15 with MAX_BEATS=8 -> row length of 8 beats.
